// File: rtl/mult_share_arbiter.sv
// Round-robin front-end sharing one registered 8x8 multiplier among NUM_REQ requesters.
// Define MULT_ARB_STATS_EN to add per-requester saturating grant counters (stat_sel/stat_cnt).
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 mul_en,
  output logic [7:0]           mul_a,
  output logic [7:0]           mul_b,
  input  logic [15:0]          mul_p,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_p,
`ifdef MULT_ARB_STATS_EN
  input  logic [IDW-1:0]       stat_sel,
  output logic [15:0]          stat_cnt,
`endif
  input  logic                 rsp_ready
);

  logic           v1, v2;
  logic [IDW-1:0] id1, id2;
  logic [IDW-1:0] rr_ptr;
  logic           advance;
  logic           grant_any;
  logic [IDW-1:0] g;
  logic [IDW-1:0] idx;
  logic [7:0]     a_sl [NUM_REQ];
  logic [7:0]     b_sl [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_sl[i] = req_a[8*i +: 8];
    assign b_sl[i] = req_b[8*i +: 8];
  end

  // The whole pipeline moves only when the output stage is empty or being drained.
  assign advance = !v2 || rsp_ready;
  assign mul_en  = advance;

  always_comb begin
    grant_any = 1'b0;
    g         = '0;
    idx       = '0;
    if (advance) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
        if (!grant_any && req_valid[idx]) begin
          grant_any = 1'b1;
          g         = idx;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_any) req_ready[g] = 1'b1;
  end

  assign mul_a = grant_any ? a_sl[g] : 8'h00;
  assign mul_b = grant_any ? b_sl[g] : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      id1    <= '0;
      id2    <= '0;
      rr_ptr <= IDW'(NUM_REQ - 1);
    end else if (advance) begin
      v2  <= v1;
      id2 <= id1;
      v1  <= grant_any;
      id1 <= g;
      if (grant_any) rr_ptr <= g;
    end
  end

  assign rsp_valid = v2;
  assign rsp_id    = id2;
  assign rsp_p     = mul_p;

`ifdef MULT_ARB_STATS_EN
  logic [15:0] grant_cnt [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
    end else if (grant_any && grant_cnt[g] != 16'hFFFF) begin
      grant_cnt[g] <= grant_cnt[g] + 16'd1;
    end
  end

  assign stat_cnt = grant_cnt[stat_sel];
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: registered multiplier model plus an ID/product scoreboard.
`timescale 1ns/1ps
module tb_mult_share_arbiter;
  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ*8-1:0] req_a = '0;
  logic [NUM_REQ*8-1:0] req_b = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 mul_en;
  logic [7:0]           mul_a, mul_b;
  logic [15:0]          mul_p = '0;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [15:0]          rsp_p;
  logic                 rsp_ready = 1'b1;
`ifdef MULT_ARB_STATS_EN
  logic [IDW-1:0]       stat_sel = '0;
  logic [15:0]          stat_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_rsp = 0;

  typedef struct {
    logic [IDW-1:0] id;
    logic [15:0]    p;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  mult_share_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_en    (mul_en),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
`ifdef MULT_ARB_STATS_EN
    .stat_sel  (stat_sel),
    .stat_cnt  (stat_cnt),
`endif
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  // Two-stage multiplier: operand registers, then product register, both on mul_en.
  logic [7:0] ra = '0, rb = '0;
  always @(posedge clk) begin
    if (mul_en) begin
      ra    <= mul_a;
      rb    <= mul_b;
      mul_p <= ra * rb;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got id=%0d p=%h, required no response", rsp_id, rsp_p);
        end else begin
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_p !== e.p) begin
            n_err++;
            $display("FAIL sb_rsp: got id=%0d p=%h, required id=%0d p=%h", rsp_id, rsp_p, e.id, e.p);
          end
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id = IDW'(i);
          e.p  = 16'(req_a[8*i +: 8]) * 16'(req_b[8*i +: 8]);
          sb.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send(input int id, input logic [7:0] a, input logic [7:0] b);
    int  t;
    bit  done;
    req_a[8*id +: 8] = a;
    req_b[8*id +: 8] = b;
    req_valid[id]    = 1'b1;
    t    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (req_ready[id]) begin
        done = 1'b1;
      end else begin
        t++;
        if (t > 100) begin
          n_cmp++;
          n_err++;
          $display("FAIL send_timeout: requester %0d not granted, required grant within 100 cycles", id);
          done = 1'b1;
        end
        tick();
      end
    end
    tick();
    req_valid[id] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_id !== '0 || req_ready !== '0 || mul_en !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b id=%0d ready=%b en=%b, required 0 0 0000 1",
               rsp_valid, rsp_id, req_ready, mul_en);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got rsp_valid=%b, required 0", rsp_valid);
    end
    tick();
  endtask

  task automatic test_basic();
    do_reset();
    req_a[7:0]   = 8'd12;
    req_b[7:0]   = 8'd13;
    req_valid    = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL basic_grant: got req_ready=%b, required 0001", req_ready);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_early: got rsp_valid=%b one cycle after handshake, required 0", rsp_valid);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== 16'd156) begin
      n_err++;
      $display("FAIL basic_rsp: got valid=%b id=%0d p=%0d, required 1 0 156", rsp_valid, rsp_id, rsp_p);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_single: got rsp_valid=%b after response, required 0", rsp_valid);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_rdy;
    logic [15:0] exp_p;
    int          j;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[8*i +: 8] = 8'(i + 1);
      req_b[8*i +: 8] = 8'd10;
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp_rdy = 4'b0001 << (k % 4);
      n_cmp++;
      if (req_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL rr_grant: cycle %0d got req_ready=%b, required %b", k, req_ready, exp_rdy);
      end
      if (k >= 2) begin
        j     = (k - 2) % 4;
        exp_p = 16'((j + 1) * 10);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== IDW'(j) || rsp_p !== exp_p) begin
          n_err++;
          $display("FAIL rr_rsp: cycle %0d got valid=%b id=%0d p=%0d, required 1 %0d %0d",
                   k, rsp_valid, rsp_id, rsp_p, j, exp_p);
        end
      end
      tick();
    end
    req_valid = '0;
    repeat (4) tick();
  endtask

  task automatic test_backpressure();
    int base;
    int t;
    do_reset();
    base      = n_rsp;
    rsp_ready = 1'b0;
    fork
      begin
        send(2, 8'd3, 8'd5);
        send(2, 8'd7, 8'd9);
        send(2, 8'd11, 8'd13);
      end
      begin
        t = 0;
        @(negedge clk);
        while (!rsp_valid && t < 50) begin
          @(negedge clk);
          t++;
        end
        if (!rsp_valid) begin
          n_cmp++;
          n_err++;
          $display("FAIL bp_timeout: got no rsp_valid, required one within 50 cycles");
        end
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          n_cmp++;
          if (mul_en !== 1'b0 || req_ready !== '0 || rsp_valid !== 1'b1 || rsp_p !== 16'd15) begin
            n_err++;
            $display("FAIL bp_freeze: cycle %0d got en=%b ready=%b valid=%b p=%0d, required 0 0000 1 15",
                     k, mul_en, req_ready, rsp_valid, rsp_p);
          end
        end
        tick();
        rsp_ready = 1'b1;
      end
    join
    repeat (6) tick();
    n_cmp++;
    if (n_rsp - base !== 3 || sb.size() != 0) begin
      n_err++;
      $display("FAIL bp_count: got %0d responses (%0d pending), required 3 (0 pending)",
               n_rsp - base, sb.size());
    end
  endtask

  task automatic test_edges();
    int base;
    base = n_rsp;
    send(1, 8'hFF, 8'hFF);
    send(3, 8'h00, 8'hAB);
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_p !== 16'hFE01) begin
      n_err++;
      $display("FAIL edge_ff: got valid=%b id=%0d p=%h, required 1 1 fe01", rsp_valid, rsp_id, rsp_p);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_p !== 16'h0000) begin
      n_err++;
      $display("FAIL edge_zero: got valid=%b id=%0d p=%h, required 1 3 0000", rsp_valid, rsp_id, rsp_p);
    end
    repeat (4) tick();
    n_cmp++;
    if (n_rsp - base !== 2) begin
      n_err++;
      $display("FAIL edge_count: got %0d responses, required 2", n_rsp - base);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    rsp_ready = 1'b1;
    send(0, 8'd5, 8'd6);
    send(1, 8'd7, 8'd8);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got rsp_valid=%b during reset, required 0", rsp_valid);
    end
    sb.delete();
    base = n_rsp;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL mid_flush: cycle %0d got rsp_valid=%b after reset, required 0", k, rsp_valid);
      end
      tick();
    end
    send(2, 8'd9, 8'd7);
    repeat (4) tick();
    n_cmp++;
    if (n_rsp - base !== 1 || sb.size() != 0) begin
      n_err++;
      $display("FAIL mid_after: got %0d responses (%0d pending), required 1 (0 pending)",
               n_rsp - base, sb.size());
    end
  endtask

`ifdef MULT_ARB_STATS_EN
  task automatic test_stats();
    int t;
    do_reset();
    stat_sel = 2'd1;
    repeat (5) send(1, 8'd2, 8'd3);
    @(negedge clk);
    n_cmp++;
    if (stat_cnt !== 16'd5) begin
      n_err++;
      $display("FAIL stat_count: got stat_cnt=%0d, required 5", stat_cnt);
    end
    tick();
    req_valid[1] = 1'b1;
    t = 0;
    while (stat_cnt !== 16'hFFFF && t < 70000) begin
      tick();
      t++;
    end
    @(negedge clk);
    n_cmp++;
    if (stat_cnt !== 16'hFFFF || req_ready[1] !== 1'b1) begin
      n_err++;
      $display("FAIL stat_sat_reach: got stat_cnt=%h ready=%b, required ffff 1", stat_cnt, req_ready[1]);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (stat_cnt !== 16'hFFFF) begin
      n_err++;
      $display("FAIL stat_sat_hold: got stat_cnt=%h after further grant, required ffff", stat_cnt);
    end
    tick();
    req_valid[1] = 1'b0;
    repeat (4) tick();
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion within 2 ms");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_edges();
    test_reset_mid();
`ifdef MULT_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
